d_flip_flop: RTL and testbench
==============================

D_FLIP_FLOP -- requirements
Module: d_flip_flop

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, meaning the data width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter RESET_VALUE, default all-zeros (WIDTH bits), meaning the value loaded into q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port d, input, WIDTH bits: the data input.
REQ-006 The block SHALL have port q, output, WIDTH bits: the registered data output.

Function
REQ-007 The block SHALL be built as a master-slave pair of level-sensitive D latches inside the module, with no behavioural edge-triggered storage.
- Master latch: transparent while clk=0, holds while clk=1.
- Slave latch: transparent while clk=1, holds while clk=0.
REQ-008 The master latch data input SHALL be RESET_VALUE when rst=1, and d when rst=0. This gating makes reset synchronous.
REQ-009 On each rising clk edge, q SHALL take the value present at the master input just before the edge. Latency is 1 edge (d sampled at edge N appears on q after edge N).
REQ-010 q SHALL hold its value between rising edges, including across the falling edge, regardless of changes on d or rst.
REQ-011 Changes of d or rst while clk is high SHALL NOT affect q until the next rising edge.
REQ-012 Changes of d or rst while clk is low SHALL NOT affect q until the next rising edge; only the value present at that edge matters.
REQ-013 When rst=1 at a rising edge, q SHALL become RESET_VALUE whatever the value of d (rst has priority).
REQ-014 An rst pulse that begins and ends between two rising edges SHALL have no effect on q.
REQ-015 Each bit SHALL be independent; there is no arithmetic and no width conversion.
REQ-016 Setup and hold are defined relative to the rising edge; d and rst SHALL be stable at that edge. The latch transparency windows SHALL NOT overlap, so d cannot race through both latches in one phase.

Reset
REQ-017 Before the first rising edge with rst=1, q SHALL be treated as undefined (X in simulation); no power-on value is guaranteed.
REQ-018 After any rising edge with rst=1, q SHALL equal RESET_VALUE and SHALL remain so while rst stays high.
REQ-019 Deasserting rst SHALL take effect at the first rising edge where rst=0; q then loads d at that edge.
REQ-020 Asserting rst mid-stream SHALL override the pending d at the next rising edge; no partial or glitch update of q is permitted.

Verification
(Clock period 10, first rising edge at t=5.)
REQ-021 Reset: rst=1, d=0 held through edge t=5 -> q=0 from t=5.
REQ-022 Data tracking: rst=0; d=1 at t=10, d=0 at t=20, d=1 at t=30, d=1 at t=40, d=0 at t=50 -> q is 1, 0, 1, 1, 0 after edges t=15, 25, 35, 45, 55 respectively. q does not change at falling edges.
REQ-023 Reset priority: d=1 and rst=1 at an edge -> q=0; rst=0 at the next edge -> q=1.
REQ-024 Mid-cycle glitch: toggle d 1->0->1 while clk is high and q=0 -> q stays 0 until the next rising edge, then q=1.
REQ-025 Short reset: rst pulse asserted and deasserted while clk is low, between edges, with q=1 and d=1 -> q remains 1.
REQ-026 Wide instance: WIDTH=8, RESET_VALUE=8'hA5; reset edge -> q=8'hA5; then d=8'h3C -> q=8'h3C after the next edge.

Source files
------------

// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge register built from a master-slave pair of level-sensitive D latches with synchronous reset
module d_flip_flop #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] master_d, master_q, slave_q;
  always_comb master_d = rst ? RESET_VALUE : d;
  always_latch if (!clk) master_q <= master_d;
  always_latch if (clk) slave_q <= master_q;
  assign q = slave_q;
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of the latch-pair register against a rising-edge reference model
module tb_d_flip_flop;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0] d1 = 1'b0;
  logic [0:0] q1;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8;
  logic [0:0] m1;
  logic [7:0] m8;
  bit v1 = 1'b0;
  bit v8 = 1'b0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  d_flip_flop u_narrow (.clk(clk), .rst(rst), .d(d1), .q(q1));
  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_wide (.clk(clk), .rst(rst), .d(d8), .q(q8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) v1 <= 1'b1;
    if (rst) v8 <= 1'b1;
    m1 <= rst ? 1'b0 : d1;
    m8 <= rst ? 8'hA5 : d8;
  end

  always @(clk) begin
    #2;
    if (v1) chk("model_q1", {63'd0, q1}, {63'd0, m1});
    if (v8) chk("model_q8", {56'd0, q8}, {56'd0, m8});
  end

  initial begin
    #7  chk("reset_q1", {63'd0, q1}, 64'd0);
        chk("reset_q8", {56'd0, q8}, 64'hA5);
    #3  rst = 1'b0; d1 = 1'b1; d8 = 8'h3C;
    #7  chk("track1_q1", {63'd0, q1}, 64'd1);
        chk("wide_load_q8", {56'd0, q8}, 64'h3C);
    #3  d1 = 1'b0;
    #7  chk("track2_q1", {63'd0, q1}, 64'd0);
    #3  d1 = 1'b1;
    #7  chk("track3_q1", {63'd0, q1}, 64'd1);
    #3  d1 = 1'b1;
    #7  chk("track4_q1", {63'd0, q1}, 64'd1);
    #3  d1 = 1'b0;
    #2  chk("hold_fall_q1", {63'd0, q1}, 64'd1);
    #5  chk("track5_q1", {63'd0, q1}, 64'd0);
    #3  d1 = 1'b1; rst = 1'b1; d8 = 8'hFF;
    #7  chk("rst_prio_q1", {63'd0, q1}, 64'd0);
        chk("rst_prio_q8", {56'd0, q8}, 64'hA5);
    #3  rst = 1'b0;
    #7  chk("rst_release_q1", {63'd0, q1}, 64'd1);
        chk("rst_release_q8", {56'd0, q8}, 64'hFF);
    #3  d1 = 1'b0;
    #6  d1 = 1'b1;
    #1  d1 = 1'b0;
    #1  d1 = 1'b1;
    #1  chk("glitch_hold_q1", {63'd0, q1}, 64'd0);
    #8  chk("glitch_load_q1", {63'd0, q1}, 64'd1);
    #4  rst = 1'b1;
    #2  rst = 1'b0;
    #1  chk("short_rst_low_q1", {63'd0, q1}, 64'd1);
    #3  chk("short_rst_edge_q1", {63'd0, q1}, 64'd1);
        chk("short_rst_edge_q8", {56'd0, q8}, 64'hFF);
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
